dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory `dm`.
- Port 0 is the CPU data port; port 1 is a secondary master (DMA/debug loader).
- Serialises accesses with round-robin arbitration.
- Turns byte-enabled (sub-word) stores into read-modify-write sequences, because `dm` only supports whole-word writes.

---
 rtl/dm_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and access sequencer in front of
// the single-port word-wide data memory `dm`. Port 0 is the CPU data port,
// port 1 a secondary master (DMA / debug loader). Sub-word stores become a
// read-modify-write pair because `dm` only accepts whole-word writes.
//
// Optional build macro: DM_ARB_TRACE_EN prints every committed memory write.
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          Reset,
  // port 0: CPU data port
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  // port 1: secondary master
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  // shared registered read data
  output logic [DW-1:0] rdata,
  // memory side
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_RE,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t        state;
  state_t        state_nxt;

  logic          last_grant;
  logic          cur_port;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] merged;

  logic          grant_valid;
  logic          grant_port;
  logic          g_we;
  logic [3:0]    g_be;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] merge_word;
  logic          we_state;

  // Round-robin pick: a lone request wins, a tie goes to the port not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (m0_req && m1_req) begin
      grant_valid = 1'b1;
      grant_port  = ~last_grant;
    end else if (m0_req) begin
      grant_valid = 1'b1;
      grant_port  = 1'b0;
    end else if (m1_req) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
    end
  end

  // Request-field mux for the port being granted
  always_comb begin
    g_we    = m0_we;
    g_be    = m0_be;
    g_addr  = m0_addr;
    g_wdata = m0_wdata;
    if (grant_port) begin
      g_we    = m1_we;
      g_be    = m1_be;
      g_addr  = m1_addr;
      g_wdata = m1_wdata;
    end
  end

  // Byte merge for read-modify-write: enabled lanes from the store, rest from dm
  always_comb begin
    merge_word = mem_RD;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lat_be[i]) merge_word[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  // Next-state and memory-side controls
  always_comb begin
    state_nxt = state;
    mem_RE    = 1'b0;
    we_state  = 1'b0;
    mem_WD    = '0;
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!lat_we) begin
          mem_RE    = 1'b1;
          state_nxt = RESP;
        end else if (lat_be == 4'b1111) begin
          we_state  = 1'b1;
          mem_WD    = lat_wdata;
          state_nxt = RESP;
        end else if (lat_be == 4'b0000) begin
          state_nxt = RESP;
        end else begin
          mem_RE    = 1'b1;
          state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        we_state  = 1'b1;
        mem_WD    = merged;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A reset cycle must never commit a write, even halfway through an RMW
  assign mem_WE = we_state & Reset;
  assign mem_A  = lat_addr & WORD_MASK;
  assign m0_ack = (state == RESP) && !cur_port;
  assign m1_ack = (state == RESP) &&  cur_port;

  // State register
  always_ff @(posedge clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant bookkeeping, latched request, merged word and read data
  always_ff @(posedge clk) begin
    if (!Reset) begin
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      merged     <= '0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        last_grant <= grant_port;
        cur_port   <= grant_port;
        lat_we     <= g_we;
        lat_be     <= g_be;
        lat_addr   <= g_addr;
        lat_wdata  <= g_wdata;
      end
      if (state == ACCESS) begin
        if (!lat_we) rdata  <= mem_RD;
        else         merged <= merge_word;
      end
    end
  end

`ifdef DM_ARB_TRACE_EN
  // Trace every write that actually reaches dm
  always_ff @(posedge clk) begin
    if (mem_WE) $display("%d@arb m%0d: *%h <= %h", $time, cur_port, mem_A, mem_WD);
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural dm model.
module tb_dm_arbiter;

  logic        clk;
  logic        Reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;
  logic        mem_RE, mem_WE;

  int total = 0;
  int bad   = 0;
  int re_cnt = 0, we_cnt = 0, both_cnt = 0;

  logic [31:0] mem [0:63];

  dm_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .Reset(Reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_RE(mem_RE), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A[7:2]];

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    if (mem_RE) re_cnt <= re_cnt + 1;
    if (mem_WE) we_cnt <= we_cnt + 1;
    if (mem_RE && mem_WE) both_cnt <= both_cnt + 1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic drive(input bit p, input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!p) begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Issue one transaction, measure cycles from sampling edge to own ack
  task automatic run_op(input string tag, input bit p, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                        input bit chk_rd, input logic [31:0] exp_rd);
    int lat;
    bit got, other;
    lat = 0; got = 1'b0; other = 1'b0;
    drive(p, 1'b1, we, be, addr, wd);
    while (!got && lat < 8) begin
      tick();
      lat++;
      if (p ? m1_ack : m0_ack) got = 1'b1;
      if (p ? m0_ack : m1_ack) other = 1'b1;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " other ack"}, {31'd0, other}, 32'd0);
    if (chk_rd) chk({tag, " rdata"}, rdata, exp_rd);
    drive(p, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();
  endtask

  initial begin
    int re0, we0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h12345678;   // byte 0x10
    mem[8] = 32'h11223344;   // byte 0x20
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();
    tick();
    chk("rst m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst mem_RE", {31'd0, mem_RE}, 32'd0);
    chk("rst mem_WE", {31'd0, mem_WE}, 32'd0);
    Reset = 1'b1;

    // m0 read of 0x10 with junk in addr[1:0]
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'h13, '0);
    chk("rd idle RE", {31'd0, mem_RE}, 32'd0);
    tick();
    chk("rd N+1 RE", {31'd0, mem_RE}, 32'd1);
    chk("rd N+1 WE", {31'd0, mem_WE}, 32'd0);
    chk("rd N+1 addr", mem_A, 32'h10);
    chk("rd N+1 ack", {31'd0, m0_ack}, 32'd0);
    tick();
    chk("rd N+2 ack0", {31'd0, m0_ack}, 32'd1);
    chk("rd N+2 ack1", {31'd0, m1_ack}, 32'd0);
    chk("rd N+2 RE", {31'd0, mem_RE}, 32'd0);
    chk("rd rdata", rdata, 32'h12345678);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();
    chk("rd ack drop", {31'd0, m0_ack}, 32'd0);

    // Simultaneous requests after reset: m0 first, m1 three cycles later
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h20, '0);
    tick();
    tick();
    chk("tie m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("tie m1 wait", {31'd0, m1_ack}, 32'd0);
    chk("tie rdata0", rdata, 32'h12345678);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();
    tick();
    chk("tie mid ack1", {31'd0, m1_ack}, 32'd0);
    tick();
    chk("tie m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("tie m0 quiet", {31'd0, m0_ack}, 32'd0);
    chk("tie rdata1", rdata, 32'h11223344);
    // Both keep requesting: grants alternate starting with m0
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'h10, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      tick();
      chk($sformatf("alt%0d m0_ack", k), {31'd0, m0_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d m1_ack", k), {31'd0, m1_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();

    // m1 partial write, fields scrambled after grant must not matter
    drive(1'b1, 1'b1, 1'b1, 4'b0010, 32'h20, 32'hAABBCCDD);
    tick();
    chk("rmw N+1 RE", {31'd0, mem_RE}, 32'd1);
    chk("rmw N+1 WE", {31'd0, mem_WE}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 32'h30, 32'h00000000);
    tick();
    chk("rmw N+2 RE", {31'd0, mem_RE}, 32'd0);
    chk("rmw N+2 WE", {31'd0, mem_WE}, 32'd1);
    chk("rmw N+2 WD", mem_WD, 32'h1122CC44);
    chk("rmw N+2 addr", mem_A, 32'h20);
    chk("rmw N+2 ack", {31'd0, m1_ack}, 32'd0);
    tick();
    chk("rmw N+3 ack", {31'd0, m1_ack}, 32'd1);
    chk("rmw mem", mem[8], 32'h1122CC44);
    chk("rmw rdata kept", rdata, 32'h11223344);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();
    run_op("rmw readback", 1'b1, 1'b0, 4'b0000, 32'h20, '0, 2, 1'b1, 32'h1122CC44);

    // m0 full-word write
    re0 = re_cnt; we0 = we_cnt;
    drive(1'b0, 1'b1, 1'b1, 4'b1111, 32'h24, 32'hDEADBEEF);
    tick();
    chk("full N+1 WE", {31'd0, mem_WE}, 32'd1);
    chk("full N+1 RE", {31'd0, mem_RE}, 32'd0);
    chk("full N+1 WD", mem_WD, 32'hDEADBEEF);
    tick();
    chk("full N+2 ack", {31'd0, m0_ack}, 32'd1);
    chk("full mem", mem[9], 32'hDEADBEEF);
    chk("full WE count", we_cnt - we0, 32'd1);
    chk("full RE count", re_cnt - re0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    tick();

    // be=0 write: acked, no memory traffic
    re0 = re_cnt; we0 = we_cnt;
    run_op("be0", 1'b0, 1'b1, 4'b0000, 32'h24, 32'h55555555, 2, 1'b1, 32'h1122CC44);
    chk("be0 RE count", re_cnt - re0, 32'd0);
    chk("be0 WE count", we_cnt - we0, 32'd0);
    chk("be0 mem", mem[9], 32'hDEADBEEF);

    // Reset landing on the RMW_WR cycle
    drive(1'b0, 1'b1, 1'b1, 4'b0001, 32'h20, 32'h000000FF);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rstrmw WE", {31'd0, mem_WE}, 32'd0);
    chk("rstrmw ack", {31'd0, m0_ack}, 32'd0);
    tick();
    chk("rstrmw mem", mem[8], 32'h1122CC44);
    chk("rstrmw ack after", {31'd0, m0_ack}, 32'd0);
    chk("rstrmw RE after", {31'd0, mem_RE}, 32'd0);
    chk("rstrmw WE after", {31'd0, mem_WE}, 32'd0);
    chk("rstrmw addr after", mem_A, 32'd0);
    chk("rstrmw rdata after", rdata, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, '0, '0);
    Reset = 1'b1;
    tick();
    chk("rstrmw no late ack", {31'd0, m0_ack}, 32'd0);

    run_op("post rst rd", 1'b0, 1'b0, 4'b0000, 32'h24, '0, 2, 1'b1, 32'hDEADBEEF);
    chk("RE/WE overlap", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
